// File: rtl/counter_sched_if.sv
// counter_sched_if: requester handshake plus counter control pins.
// master = requester/counter side, slave = scheduler.
interface counter_sched_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
);
  logic [1:0]       req;
  logic [WIDTH-1:0] start0;
  logic [LEN_W-1:0] len0;
  logic [WIDTH-1:0] start1;
  logic [LEN_W-1:0] len1;
  logic [1:0]       ack;
  logic [1:0]       done;
  logic             busy;
  logic             grant_id;
  logic             cnt_load_sel;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_oe;

  modport master (
    output req, start0, len0, start1, len1,
    input  ack, done, busy, grant_id,
    input  cnt_load_sel, cnt_load_val, cnt_oe
  );

  modport slave (
    input  req, start0, len0, start1, len1,
    output ack, done, busy, grant_id,
    output cnt_load_sel, cnt_load_val, cnt_oe
  );
endinterface

// File: rtl/counter_sched.sv
// counter_sched: shares one counter between two requesters (IDLE/LOAD/RUN/DONE).
// Define CNT_SCHED_FIXED_PRIO_EN for fixed priority instead of round-robin.
module counter_sched #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  counter_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             win;
  logic [WIDTH-1:0] start_q, start_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             ls_q, ls_d;
  logic             oe_q, oe_d;

`ifdef CNT_SCHED_FIXED_PRIO_EN
  assign win = ~bus.req[0];
`else
  logic ptr_q;

  // Next tie goes to whoever did not win the run just finished.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (state_q == DONE) begin
      ptr_q <= ~gnt_q;
    end
  end

  assign win = (&bus.req) ? ptr_q : bus.req[1];
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    start_d = start_q;
    len_d   = len_q;
    rem_d   = rem_q;
    ack_d   = 2'b00;
    done_d  = 2'b00;
    busy_d  = 1'b0;
    ls_d    = 1'b0;
    oe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = LOAD;
          gnt_d   = win;
          start_d = win ? bus.start1 : bus.start0;
          len_d   = win ? bus.len1 : bus.len0;
          ack_d   = {win, ~win};
          busy_d  = 1'b1;
          ls_d    = 1'b1;
        end
      end
      LOAD: begin
        busy_d = 1'b1;
        if (len_q != '0) begin
          state_d = RUN;
          rem_d   = len_q;
          oe_d    = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = {gnt_q, ~gnt_q};
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (rem_q == LEN_W'(1)) begin
          state_d = DONE;
          done_d  = {gnt_q, ~gnt_q};
        end else begin
          rem_d = rem_q - LEN_W'(1);
          oe_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      start_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      ack_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      ls_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ls_q    <= ls_d;
      oe_q    <= oe_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;
  assign bus.grant_id     = gnt_q;
  assign bus.cnt_load_sel = ls_q;
  assign bus.cnt_load_val = start_q;
  assign bus.cnt_oe       = oe_q;

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed runs with a scoreboard of expected grants/results.
// A simple behavioural counter stands in for the shared counter instance.
module tb_counter_sched;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  counter_sched_if #(.WIDTH(8), .LEN_W(8)) bus ();

  counter_sched #(.WIDTH(8), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running counter: loads on load_sel, otherwise increments.
  logic [7:0] cnt;
  always @(posedge clk) begin
    if (bus.cnt_load_sel) cnt <= bus.cnt_load_val;
    else                  cnt <= cnt + 8'd1;
  end

  typedef struct {
    logic       g;
    logic [7:0] start;
    logic [7:0] len;
    logic [7:0] fin;
    int         gap;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_done = -100;
  int ack_cyc = 0;
  int n_oe = 0;
  int n_ls = 0;
  int t0 = 0;
  bit hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic push(input logic g, input logic [7:0] s,
                      input logic [7:0] l, input int gap);
    exp_t e;
    e.g = g;
    e.start = s;
    e.len = l;
    e.fin = s + l;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic watch(input int maxc, input bit drain);
    int k;
    k = 0;
    while (k < maxc && sb.size() > 0) begin
      step();
      k++;
      if (bus.cnt_oe) n_oe++;
      if (bus.cnt_load_sel) n_ls++;
      if (bus.ack != 2'b00) begin
        chk("ack_bits", 32'(bus.ack), sb[0].g ? 2 : 1);
        chk("ack_nodone", 32'(bus.done), 0);
        chk("ack_ld_sel", 32'(bus.cnt_load_sel), 1);
        chk("ack_ld_val", 32'(bus.cnt_load_val), 32'(sb[0].start));
        chk("ack_gid", 32'(bus.grant_id), 32'(sb[0].g));
        chk("ack_busy", 32'(bus.busy), 1);
        if (sb[0].gap > 0) chk("grant_gap", cyc - last_done, sb[0].gap);
        ack_cyc = cyc;
        n_oe = bus.cnt_oe ? 1 : 0;
        n_ls = bus.cnt_load_sel ? 1 : 0;
        if (!hold) bus.req[sb[0].g] = 1'b0;
      end
      if (bus.done != 2'b00) begin
        chk("done_bits", 32'(bus.done), sb[0].g ? 2 : 1);
        chk("done_cnt", 32'(cnt), 32'(sb[0].fin));
        chk("done_oe_cycles", n_oe, 32'(sb[0].len));
        chk("done_ls_cycles", n_ls, 1);
        chk("done_latency", cyc - ack_cyc, 32'(sb[0].len) + 1);
        chk("done_busy", 32'(bus.busy), 1);
        chk("done_oe_low", 32'(bus.cnt_oe), 0);
        last_done = cyc;
        void'(sb.pop_front());
      end
    end
    if (drain && sb.size() > 0) chk("run_timeout", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 2'b00;
    bus.start0 = 8'h00;
    bus.len0 = 8'h00;
    bus.start1 = 8'h00;
    bus.len1 = 8'h00;
    repeat (3) step();
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_gid", 32'(bus.grant_id), 0);
    chk("rst_ld_sel", 32'(bus.cnt_load_sel), 0);
    chk("rst_oe", 32'(bus.cnt_oe), 0);
    chk("rst_ld_val", 32'(bus.cnt_load_val), 0);
    rst = 1'b0;
    step();

    // Single run: ack one cycle after req sampled, counter ends 0x15.
    bus.start0 = 8'h10;
    bus.len0 = 8'd5;
    push(1'b0, 8'h10, 8'd5, 0);
    bus.req = 2'b01;
    t0 = cyc;
    watch(30, 1'b1);
    chk("single_ack_lat", ack_cyc - t0, 1);
    step();
    chk("idle_busy", 32'(bus.busy), 0);

    // Zero length: LOAD straight to DONE.
    bus.start0 = 8'h42;
    bus.len0 = 8'd0;
    push(1'b0, 8'h42, 8'd0, 0);
    bus.req = 2'b01;
    watch(30, 1'b1);

    // Maximum length: remaining count must not wrap.
    bus.start0 = 8'h01;
    bus.len0 = 8'hFF;
    push(1'b0, 8'h01, 8'hFF, 0);
    bus.req = 2'b01;
    watch(300, 1'b1);

    // Wrap of the counter itself.
    bus.start1 = 8'hFE;
    bus.len1 = 8'd3;
    push(1'b1, 8'hFE, 8'd3, 0);
    bus.req = 2'b10;
    watch(30, 1'b1);

    // Contention with both requests held.
    hold = 1'b1;
    bus.start0 = 8'h20;
    bus.len0 = 8'd2;
    bus.start1 = 8'h80;
    bus.len1 = 8'd2;
`ifdef CNT_SCHED_FIXED_PRIO_EN
    push(1'b0, 8'h20, 8'd2, 0);
    push(1'b0, 8'h20, 8'd2, 0);
    push(1'b0, 8'h20, 8'd2, 0);
`else
    push(1'b0, 8'h20, 8'd2, 0);
    push(1'b1, 8'h80, 8'd2, 0);
    push(1'b0, 8'h20, 8'd2, 0);
    push(1'b1, 8'h80, 8'd2, 0);
`endif
    bus.req = 2'b11;
    watch(80, 1'b1);
    bus.req = 2'b00;
    hold = 1'b0;
    step();
    step();
    chk("cont_no_extra_ack", 32'(bus.ack), 0);

    // Busy blocking: requester 0 raises req during requester 1's RUN.
    bus.start1 = 8'h30;
    bus.len1 = 8'd4;
    push(1'b1, 8'h30, 8'd4, 0);
    bus.req = 2'b10;
    watch(3, 1'b0);
    bus.start0 = 8'h50;
    bus.len0 = 8'd1;
    push(1'b0, 8'h50, 8'd1, 2);
    bus.req[0] = 1'b1;
    watch(30, 1'b1);
    step();

    // Mid-run reset in RUN cycle 2 of a length-10 run.
    bus.start0 = 8'h60;
    bus.len0 = 8'd10;
    bus.req = 2'b01;
    step();
    chk("mr_ack", 32'(bus.ack), 1);
    bus.req = 2'b00;
    step();
    step();
    chk("mr_in_run", 32'(bus.cnt_oe), 1);
    rst = 1'b1;
    step();
    chk("mr_outputs", 32'({bus.ack, bus.done, bus.busy, bus.grant_id,
                           bus.cnt_load_sel, bus.cnt_oe, bus.cnt_load_val}), 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("mr_no_done", 32'(bus.done), 0);
    end

    // After reset a tie goes to requester 0 first, then 1 is served.
    bus.start0 = 8'h07;
    bus.len0 = 8'd1;
    bus.start1 = 8'h09;
    bus.len1 = 8'd1;
    push(1'b0, 8'h07, 8'd1, 0);
    push(1'b1, 8'h09, 8'd1, 0);
    bus.req = 2'b11;
    watch(30, 1'b1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
